// File: rtl/clk_en_pkg.sv
// Shared types for the lock-qualified clock-enable NCO block.
// Holds the lock FSM encoding and the settle-counter sizing helper.
package clk_en_pkg;

   typedef enum logic [1:0] {
      WAIT_LOCK = 2'd0,
      SETTLE    = 2'd1,
      RUN       = 2'd2
   } lock_state_e;

   // Counter only needs to reach LOCK_CYCLES-1.
   function automatic int settle_cnt_w(input int lock_cycles);
      return (lock_cycles < 2) ? 1 : $clog2(lock_cycles);
   endfunction

endpackage

// File: rtl/nco_channel.sv
// One phase-accumulator clock-enable channel with glitch-free increment update.
// The pending increment is only promoted on a wrap or while the channel is idle.
module nco_channel
   import clk_en_pkg::*;
#(
   parameter int ACC_W = 24
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             advance,
   input  logic [ACC_W-1:0] inc,
   input  logic             inc_load,
   output logic             ce
);

   logic [ACC_W-1:0] acc;
   logic [ACC_W-1:0] inc_active;
   logic [ACC_W-1:0] inc_pending;
   logic             pend_valid;
   logic [ACC_W:0]   sum;
   logic             carry;
   logic             take_pend;

   assign sum       = {1'b0, acc} + {1'b0, inc_active};
   assign carry     = advance & sum[ACC_W];
   assign take_pend = pend_valid & (carry | ~advance);

   always_ff @(posedge clk) begin
      if (reset) begin
         acc         <= '0;
         inc_active  <= '0;
         inc_pending <= '0;
         pend_valid  <= 1'b0;
         ce          <= 1'b0;
      end else begin
         acc <= advance ? sum[ACC_W-1:0] : '0;
         ce  <= carry;
         if (take_pend)
            inc_active <= inc_pending;
         // A load on the transfer cycle hands over the old value and stays pending.
         if (inc_load) begin
            inc_pending <= inc;
            pend_valid  <= 1'b1;
         end else if (take_pend) begin
            pend_valid  <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/clk_enable_nco.sv
// Lock-qualified bank of fractional clock-enable NCOs driven from the PLL clock.
// Channels run only after pll_lock has held for LOCK_CYCLES; lock losses are counted.
module clk_enable_nco
   import clk_en_pkg::*;
#(
   parameter int CHANNELS    = 2,
   parameter int ACC_W       = 24,
   parameter int LOCK_CYCLES = 1024,
   parameter int LOST_W      = 8
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      pll_lock,
   input  logic [CHANNELS*ACC_W-1:0] inc,
   input  logic [CHANNELS-1:0]       inc_load,
   input  logic [CHANNELS-1:0]       chan_en,
   output logic [CHANNELS-1:0]       ce,
   output logic                      ready,
   output logic [LOST_W-1:0]         lost_cnt
);

   localparam int CNT_W = settle_cnt_w(LOCK_CYCLES);

   lock_state_e         state, state_nx;
   logic [CNT_W-1:0]    settle_cnt;
   logic                settle_done;
   logic                settle_start;
   logic                settle_step;
   logic                lose;
   logic [CHANNELS-1:0] advance;

   assign settle_done = (settle_cnt == CNT_W'(LOCK_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (reset) state <= WAIT_LOCK;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         WAIT_LOCK: if (pll_lock) state_nx = SETTLE;
         SETTLE: begin
            if (!pll_lock)        state_nx = WAIT_LOCK;
            else if (settle_done) state_nx = RUN;
         end
         RUN:       if (!pll_lock) state_nx = WAIT_LOCK;
         default:   state_nx = WAIT_LOCK;
      endcase
   end

   always_comb begin
      settle_start = (state == WAIT_LOCK) & pll_lock;
      settle_step  = (state == SETTLE) & pll_lock & ~settle_done;
      lose         = (state == RUN) & ~pll_lock;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         settle_cnt <= '0;
         ready      <= 1'b0;
         lost_cnt   <= '0;
      end else begin
         if (settle_start)     settle_cnt <= CNT_W'(1);
         else if (settle_step) settle_cnt <= settle_cnt + CNT_W'(1);
         ready <= (state_nx == RUN);
         if (lose && (lost_cnt != '1))
            lost_cnt <= lost_cnt + LOST_W'(1);
      end
   end

   // On the lock-loss edge channels stop, which clears acc and ce at once.
   assign advance = chan_en & {CHANNELS{ready & ~lose}};

   for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
      nco_channel #(.ACC_W(ACC_W)) u_chan (
         .clk      (clk),
         .reset    (reset),
         .advance  (advance[g]),
         .inc      (inc[g*ACC_W +: ACC_W]),
         .inc_load (inc_load[g]),
         .ce       (ce[g])
      );
   end

endmodule

// File: tb/tb_clk_enable_nco.sv
// Randomised and directed bench for clk_enable_nco against a behavioural model.
// Model tracks a lock streak and integer phases rather than the FSM encoding.
module tb_clk_enable_nco;

   localparam int CH = 2;
   localparam int AW = 8;
   localparam int LC = 16;
   localparam int LW = 8;
   localparam int MODV = 1 << AW;

   logic             clk = 1'b0;
   logic             reset;
   logic             pll_lock;
   logic [CH*AW-1:0] inc;
   logic [CH-1:0]    inc_load;
   logic [CH-1:0]    chan_en;
   logic [CH-1:0]    ce;
   logic             ready;
   logic [LW-1:0]    lost_cnt;

   always #5 clk = ~clk;

   clk_enable_nco #(.CHANNELS(CH), .ACC_W(AW), .LOCK_CYCLES(LC), .LOST_W(LW)) dut (
      .clk      (clk),
      .reset    (reset),
      .pll_lock (pll_lock),
      .inc      (inc),
      .inc_load (inc_load),
      .chan_en  (chan_en),
      .ce       (ce),
      .ready    (ready),
      .lost_cnt (lost_cnt)
   );

   int n_cmp = 0;
   int n_bad = 0;

   int         m_streak;
   bit         m_ready;
   int         m_lost;
   int         m_phase [CH];
   int         m_act   [CH];
   int         m_pend  [CH];
   bit         m_pv    [CH];
   logic [CH-1:0] m_ce;

   // Advance the model by one clock using the inputs seen at the edge.
   task automatic tick();
      bit lose;
      @(posedge clk);
      if (reset) begin
         m_streak = 0; m_ready = 0; m_lost = 0; m_ce = '0;
         for (int i = 0; i < CH; i++) begin
            m_phase[i] = 0; m_act[i] = 0; m_pend[i] = 0; m_pv[i] = 0;
         end
      end else begin
         lose = m_ready && !pll_lock;
         for (int i = 0; i < CH; i++) begin
            bit adv;
            bit carry;
            adv   = m_ready && chan_en[i] && !lose;
            carry = 0;
            if (adv) begin
               carry      = (m_phase[i] + m_act[i]) >= MODV;
               m_phase[i] = (m_phase[i] + m_act[i]) % MODV;
            end else begin
               m_phase[i] = 0;
            end
            m_ce[i] = carry;
            if (m_pv[i] && (carry || !adv)) begin
               m_act[i] = m_pend[i];
               m_pv[i]  = 0;
            end
            if (inc_load[i]) begin
               m_pend[i] = int'(inc[i*AW +: AW]);
               m_pv[i]   = 1;
            end
         end
         if (lose && m_lost < (1 << LW) - 1) m_lost++;
         m_streak = pll_lock ? m_streak + 1 : 0;
         m_ready  = pll_lock && (m_ready || m_streak >= LC);
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b1; pll_lock = 1'b0; inc = '0; inc_load = '0; chan_en = '0;
      tick(); tick();
      reset = 1'b0;
   endtask

   task automatic load_inc(input int ch, input int val);
      inc[ch*AW +: AW] = AW'(val);
      inc_load[ch] = 1'b1;
      tick();
      inc_load = '0;
   endtask

   task automatic test_reset();
      reset = 1'b1; pll_lock = 1'b1; inc = '1; inc_load = '1; chan_en = '1;
      tick();
      inc_load = '0;
      n_cmp++;
      if (ce !== '0 || ready !== 1'b0 || lost_cnt !== '0) begin
         n_bad++;
         $display("FAIL reset_state ce=%b ready=%b lost=%0d want 0/0/0", ce, ready, lost_cnt);
      end
      do_reset();
   endtask

   task automatic test_lock_qualify();
      int rise;
      do_reset();
      pll_lock = 1'b1;
      rise = -1;
      for (int c = 1; c <= 24; c++) begin
         tick();
         n_cmp++;
         if (ready !== m_ready || lost_cnt !== LW'(m_lost)) begin
            n_bad++;
            $display("FAIL lock_model c=%0d ready=%b want %b", c, ready, m_ready);
         end
         if (ready && rise < 0) rise = c;
      end
      n_cmp++;
      if (rise !== LC) begin
         n_bad++;
         $display("FAIL ready_latency got %0d want %0d", rise, LC);
      end
      // Glitch low at settle count 10.
      do_reset();
      pll_lock = 1'b1;
      repeat (10) tick();
      pll_lock = 1'b0;
      tick();
      pll_lock = 1'b1;
      for (int c = 1; c <= LC; c++) begin
         tick();
         n_cmp++;
         if (ready !== (c == LC) || lost_cnt !== '0) begin
            n_bad++;
            $display("FAIL glitch_relock c=%0d ready=%b lost=%0d want %b/0", c, ready, lost_cnt, c == LC);
         end
      end
   endtask

   task automatic wait_ready(input string tag);
      int k;
      k = 0;
      while (!ready && k < 60) begin tick(); k++; end
      n_cmp++;
      if (!ready) begin
         n_bad++;
         $display("FAIL %s_ready_timeout ready=%b want 1", tag, ready);
      end
   endtask

   task automatic test_rate();
      int first0, cnt0, cnt1, prev0, badgap;
      do_reset();
      chan_en = 2'b11;
      inc[0 +: AW] = AW'(64); inc[AW +: AW] = AW'(3); inc_load = 2'b11;
      tick();
      inc_load = '0;
      pll_lock = 1'b1;
      wait_ready("rate");
      first0 = -1; cnt0 = 0; cnt1 = 0; prev0 = 0; badgap = 0;
      for (int k = 1; k <= 2560; k++) begin
         tick();
         n_cmp++;
         if (ce !== m_ce || ready !== m_ready) begin
            n_bad++;
            $display("FAIL rate_model k=%0d ce=%b want %b", k, ce, m_ce);
         end
         if (ce[0]) begin
            if (first0 < 0) first0 = k;
            else if (k - prev0 != 4) badgap++;
            prev0 = k;
            cnt0++;
         end
         if (ce[1]) cnt1++;
      end
      n_cmp++;
      if (first0 !== 4) begin n_bad++; $display("FAIL first_pulse got %0d want 4", first0); end
      n_cmp++;
      if (cnt0 !== 640 || badgap !== 0) begin
         n_bad++; $display("FAIL inc64_count got %0d badgap %0d want 640/0", cnt0, badgap);
      end
      n_cmp++;
      if (cnt1 !== 30) begin n_bad++; $display("FAIL inc3_count got %0d want 30", cnt1); end
   endtask

   task automatic test_runtime_update();
      int prev, np, k;
      k = 0;
      while (!ce[0] && k < 10) begin tick(); k++; end
      tick();
      load_inc(0, 128);
      prev = -2; np = 0;
      for (int c = 1; c <= 40; c++) begin
         tick();
         n_cmp++;
         if (ce !== m_ce) begin
            n_bad++; $display("FAIL update_model c=%0d ce=%b want %b", c, ce, m_ce);
         end
         if (ce[0]) begin
            n_cmp++;
            if ((c - prev) !== ((np == 0) ? 4 : 2)) begin
               n_bad++;
               $display("FAIL update_gap pulse %0d gap %0d want %0d", np, c - prev, (np == 0) ? 4 : 2);
            end
            prev = c; np++;
         end
      end
      n_cmp++;
      if (np !== 20) begin n_bad++; $display("FAIL update_pulses got %0d want 20", np); end
   endtask

   task automatic test_lock_loss();
      int first;
      pll_lock = 1'b0;
      tick();
      n_cmp++;
      if (ready !== 1'b0 || ce !== '0 || lost_cnt !== LW'(1)) begin
         n_bad++;
         $display("FAIL lock_drop ready=%b ce=%b lost=%0d want 0/00/1", ready, ce, lost_cnt);
      end
      pll_lock = 1'b1;
      wait_ready("relock");
      first = -1;
      for (int c = 1; c <= 8; c++) begin
         tick();
         n_cmp++;
         if (ce !== m_ce) begin n_bad++; $display("FAIL relock_model c=%0d ce=%b want %b", c, ce, m_ce); end
         if (ce[0] && first < 0) first = c;
      end
      n_cmp++;
      if (first !== 2) begin n_bad++; $display("FAIL relock_phase got %0d want 2", first); end
      for (int n = 0; n < 300; n++) begin
         pll_lock = 1'b0; tick();
         pll_lock = 1'b1; repeat (LC + 1) tick();
      end
      n_cmp++;
      if (lost_cnt !== 8'd255 || lost_cnt !== LW'(m_lost)) begin
         n_bad++; $display("FAIL lost_saturate got %0d want 255", lost_cnt);
      end
   endtask

   task automatic test_reset_mid_run();
      int pulses;
      load_inc(0, 32);
      reset = 1'b1;
      tick();
      n_cmp++;
      if (ce !== '0 || ready !== 1'b0 || lost_cnt !== '0) begin
         n_bad++;
         $display("FAIL reset_mid_run ce=%b ready=%b lost=%0d want 0/0/0", ce, ready, lost_cnt);
      end
      reset = 1'b0; pll_lock = 1'b1; chan_en = 2'b11;
      pulses = 0;
      for (int c = 0; c < LC + 300; c++) begin
         tick();
         if (ce != '0) pulses++;
      end
      n_cmp++;
      if (pulses !== 0 || ready !== 1'b1) begin
         n_bad++; $display("FAIL pending_discarded pulses=%0d ready=%b want 0/1", pulses, ready);
      end
   endtask

   task automatic test_random();
      do_reset();
      pll_lock = 1'b1; chan_en = 2'b11;
      for (int c = 0; c < 4000; c++) begin
         reset    = ($urandom_range(0, 999) == 0);
         if ($urandom_range(0, 199) == 0) pll_lock = ~pll_lock;
         else if (!pll_lock && $urandom_range(0, 3) == 0) pll_lock = 1'b1;
         if ($urandom_range(0, 63) == 0) chan_en[$urandom_range(0, CH-1)] ^= 1'b1;
         for (int i = 0; i < CH; i++) begin
            case ($urandom_range(0, 5))
               0:       inc[i*AW +: AW] = '1;
               1:       inc[i*AW +: AW] = '0;
               default: inc[i*AW +: AW] = AW'($urandom_range(1, MODV - 1));
            endcase
            inc_load[i] = ($urandom_range(0, 11) == 0);
         end
         tick();
         n_cmp++;
         if (ce !== m_ce || ready !== m_ready || lost_cnt !== LW'(m_lost)) begin
            n_bad++;
            $display("FAIL random c=%0d ce=%b/%b ready=%b/%b lost=%0d/%0d",
                     c, ce, m_ce, ready, m_ready, lost_cnt, m_lost);
         end
      end
      inc_load = '0; reset = 1'b0;
   endtask

   initial begin
      test_reset();
      test_lock_qualify();
      test_rate();
      test_runtime_update();
      test_lock_loss();
      test_reset_mid_run();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
